// File: rtl/flash_byte_read_fsm.sv
// rtl/flash_byte_read_fsm.sv - single-byte Avalon-MM flash read engine behind the access arbiter
// Fetches the 32-bit word holding the requested byte, returns that byte or a timeout marker.
module flash_byte_read_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  TIMEOUT_DATA   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_target_state_machine,
  input  logic [31:0] input_arguments,
  output logic        target_state_machine_finished,
  output logic [7:0]  recieved_data,
  output logic        timeout_flag,
  output logic        flash_mem_read,
  output logic [22:0] flash_mem_address,
  output logic [3:0]  flash_mem_byteenable,
  input  logic        flash_mem_waitrequest,
  input  logic [31:0] flash_mem_readdata,
  input  logic        flash_mem_readdatavalid
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [15:0] COUNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [15:0] counter, counter_next;
  logic [22:0] word_addr;
  logic [1:0]  lane;
  logic        load_result;
  logic [7:0]  result_data;
  logic        result_timeout;
  logic [7:0]  lane_byte;
  logic        unused_arg_bits;

  // Bits above the 25-bit byte address are don't-care.
  assign unused_arg_bits = ^input_arguments[31:25];

  always_comb begin
    lane_byte = flash_mem_readdata[7:0];
    case (lane)
      2'd0: lane_byte = flash_mem_readdata[7:0];
      2'd1: lane_byte = flash_mem_readdata[15:8];
      2'd2: lane_byte = flash_mem_readdata[23:16];
      2'd3: lane_byte = flash_mem_readdata[31:24];
      default: lane_byte = flash_mem_readdata[7:0];
    endcase
  end

  always_comb begin
    state_next     = state;
    counter_next   = counter;
    load_result    = 1'b0;
    result_data    = TIMEOUT_DATA;
    result_timeout = 1'b1;
    case (state)
      IDLE: begin
        if (start_target_state_machine) begin
          state_next   = ISSUE;
          counter_next = 16'd0;
        end
      end
      ISSUE: begin
        // The timeout budget covers the whole request, including slave stalls.
        if (counter == COUNT_LAST) begin
          state_next  = DONE;
          load_result = 1'b1;
        end else begin
          counter_next = counter + 16'd1;
          if (!flash_mem_waitrequest) state_next = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        // Valid data wins over a coincident timeout.
        if (flash_mem_readdatavalid) begin
          state_next     = DONE;
          load_result    = 1'b1;
          result_data    = lane_byte;
          result_timeout = 1'b0;
        end else if (counter == COUNT_LAST) begin
          state_next  = DONE;
          load_result = 1'b1;
        end else begin
          counter_next = counter + 16'd1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      counter       <= 16'd0;
      word_addr     <= 23'd0;
      lane          <= 2'd0;
      recieved_data <= 8'h00;
      timeout_flag  <= 1'b0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      if (state == IDLE && start_target_state_machine) begin
        word_addr <= input_arguments[24:2];
        lane      <= input_arguments[1:0];
      end
      if (load_result) begin
        recieved_data <= result_data;
        timeout_flag  <= result_timeout;
      end
    end
  end

  assign flash_mem_read                = (state == ISSUE);
  assign target_state_machine_finished = (state == DONE);
  assign flash_mem_address             = word_addr;
  assign flash_mem_byteenable          = 4'b1111;

endmodule

// File: tb/tb_flash_byte_read_fsm.sv
// tb/tb_flash_byte_read_fsm.sv - directed self-checking bench for flash_byte_read_fsm
// Inputs change and outputs are checked on the falling clock edge.
module tb_flash_byte_read_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] args;
  logic        finished;
  logic [7:0]  rdata;
  logic        tflag;
  logic        mem_read;
  logic [22:0] mem_addr;
  logic [3:0]  mem_be;
  logic        waitreq;
  logic [31:0] readdata;
  logic        rvalid;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  flash_byte_read_fsm #(.TIMEOUT_CYCLES(8), .TIMEOUT_DATA(8'hFF)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .start_target_state_machine    (start),
    .input_arguments               (args),
    .target_state_machine_finished (finished),
    .recieved_data                 (rdata),
    .timeout_flag                  (tflag),
    .flash_mem_read                (mem_read),
    .flash_mem_address             (mem_addr),
    .flash_mem_byteenable          (mem_be),
    .flash_mem_waitrequest         (waitreq),
    .flash_mem_readdata            (readdata),
    .flash_mem_readdatavalid       (rvalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; args = 32'd0; waitreq = 1'b0; readdata = 32'd0; rvalid = 1'b0;
    step(); step();
    chk("rst_read", 32'(mem_read), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(rdata), 32'h00);
    chk("rst_flag", 32'(tflag), 32'd0);
    chk("rst_fin", 32'(finished), 32'd0);
    chk("byteen", 32'(mem_be), 32'hF);
    rst = 1'b0;

    // Zero-wait read of byte 6 -> word 1, lane 2
    start = 1'b1; args = 32'h0000_0006; waitreq = 1'b0; readdata = 32'hA1B2C3D4;
    step();
    chk("zw_read", 32'(mem_read), 32'd1);
    chk("zw_addr", 32'(mem_addr), 32'h1);
    chk("zw_fin0", 32'(finished), 32'd0);
    start = 1'b0;
    step();
    chk("zw_readdrop", 32'(mem_read), 32'd0);
    chk("zw_fin1", 32'(finished), 32'd0);
    rvalid = 1'b1;
    step();
    chk("zw_fin", 32'(finished), 32'd1);
    chk("zw_data", 32'(rdata), 32'hB2);
    chk("zw_flag", 32'(tflag), 32'd0);
    rvalid = 1'b0;
    step();
    chk("zw_fin_off", 32'(finished), 32'd0);
    chk("zw_hold", 32'(rdata), 32'hB2);

    // Stall four cycles, lane 3 of word 4
    start = 1'b1; args = 32'h0000_0013; waitreq = 1'b1; readdata = 32'h5A00_0000;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("st_read", 32'(mem_read), 32'd1);
      chk("st_addr", 32'(mem_addr), 32'h4);
      if (i == 4) waitreq = 1'b0;
      step();
    end
    chk("st_readdrop", 32'(mem_read), 32'd0);
    step();
    chk("st_nofin", 32'(finished), 32'd0);
    rvalid = 1'b1;
    step();
    chk("st_fin", 32'(finished), 32'd1);
    chk("st_data", 32'(rdata), 32'h5A);
    chk("st_flag", 32'(tflag), 32'd0);
    rvalid = 1'b0;
    step();

    // Spurious valid in IDLE, then in ISSUE, then timeout in WAIT_DATA
    rvalid = 1'b1; readdata = 32'h1111_1111;
    step();
    chk("sp_idle_fin", 32'(finished), 32'd0);
    chk("sp_idle_data", 32'(rdata), 32'h5A);
    start = 1'b1; args = 32'h0000_0008;
    step();
    start = 1'b0;
    for (int n = 0; n < 8; n++) begin
      chk("to_nofin", 32'(finished), 32'd0);
      chk("to_data_held", 32'(rdata), 32'h5A);
      if (n >= 3) chk("to_read_low", 32'(mem_read), 32'd0);
      rvalid  = (n < 2);
      waitreq = (n < 2);
      step();
    end
    chk("to_fin", 32'(finished), 32'd1);
    chk("to_data", 32'(rdata), 32'hFF);
    chk("to_flag", 32'(tflag), 32'd1);
    step();
    chk("to_fin_off", 32'(finished), 32'd0);
    chk("to_flag_hold", 32'(tflag), 32'd1);

    // Busy start ignored; good read clears flag
    start = 1'b1; args = 32'h0000_0021; waitreq = 1'b0; readdata = 32'h0000_3C00;
    step();
    start = 1'b0;
    chk("bz_read", 32'(mem_read), 32'd1);
    chk("bz_addr", 32'(mem_addr), 32'h8);
    step();
    start = 1'b1; args = 32'h0000_0042;
    chk("bz_wait_read", 32'(mem_read), 32'd0);
    step();
    start = 1'b0;
    chk("bz_noissue", 32'(mem_read), 32'd0);
    chk("bz_addr_held", 32'(mem_addr), 32'h8);
    rvalid = 1'b1;
    step();
    chk("bz_fin", 32'(finished), 32'd1);
    chk("bz_data", 32'(rdata), 32'h3C);
    chk("bz_flag_clr", 32'(tflag), 32'd0);

    // Start held through DONE: top address, wrapped high bits discarded
    rvalid = 1'b0; start = 1'b1; args = 32'hFFFF_FFFF; readdata = 32'h9E00_0000;
    step();
    chk("bb_idle_fin", 32'(finished), 32'd0);
    chk("bb_idle_read", 32'(mem_read), 32'd0);
    step();
    start = 1'b0;
    chk("bb_read", 32'(mem_read), 32'd1);
    chk("bb_addr", 32'(mem_addr), 32'h7F_FFFF);
    step();
    rvalid = 1'b1;
    step();
    chk("bb_fin", 32'(finished), 32'd1);
    chk("bb_data", 32'(rdata), 32'h9E);
    rvalid = 1'b0;
    step();

    // Async reset mid-ISSUE
    start = 1'b1; args = 32'h0000_0004; waitreq = 1'b1;
    step();
    start = 1'b0;
    chk("ar_read_pre", 32'(mem_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_read_drop", 32'(mem_read), 32'd0);
    chk("ar_addr", 32'(mem_addr), 32'd0);
    chk("ar_data", 32'(rdata), 32'h00);
    chk("ar_fin", 32'(finished), 32'd0);
    step();
    rst = 1'b0; rvalid = 1'b1; readdata = 32'h7777_7777;
    step();
    chk("ar_post_read", 32'(mem_read), 32'd0);
    chk("ar_post_fin", 32'(finished), 32'd0);
    chk("ar_post_data", 32'(rdata), 32'h00);
    rvalid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flash_byte_read_fsm.md
Name: flash_byte_read_fsm

Overview:
- Target state machine that sits directly downstream of the shared-access arbiter.
- Receives a start pulse and a 32-bit argument (byte address) from the arbiter.
- Performs one Avalon-MM read of the flash word holding that byte, then returns the selected byte and a one-cycle finish pulse to the arbiter.
- Bounds each transaction with a timeout so a stuck flash cannot hang the arbiter's clients.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent in ISSUE+WAIT_DATA before forced completion (1..65535).
- TIMEOUT_DATA, 8'hFF, byte returned on timeout.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start_target_state_machine  in  1  request; sampled only in IDLE
- input_arguments  in  32  [24:0] byte address, [31:25] ignored
- target_state_machine_finished  out  1  one-cycle completion pulse
- recieved_data  out  8  returned byte, registered, held until next completion
- timeout_flag  out  1  1 if the last completion was a timeout, held until next completion
- flash_mem_read  out  1  Avalon read request
- flash_mem_address  out  23  word address = latched arg[24:2]
- flash_mem_byteenable  out  4  constant 4'b1111
- flash_mem_waitrequest  in  1  slave stall
- flash_mem_readdata  in  32  read word
- flash_mem_readdatavalid  in  1  read data qualifier

Behaviour:
- States: IDLE, ISSUE, WAIT_DATA, DONE. Outputs decode from registered state only; no combinational path from inputs to outputs.
- Reset (async, any time incl. mid-transaction):
  - state IDLE; flash_mem_read=0; flash_mem_address=0.
  - recieved_data=8'h00; timeout_flag=0; finished=0; counter=0.
  - Any readdatavalid arriving after reset release while in IDLE is ignored.
- IDLE: on an edge with start=1:
  - latch word address arg[24:2] and lane arg[1:0].
  - clear counter; go to ISSUE.
  - start=0 stays in IDLE.
- ISSUE: flash_mem_read=1, address stable.
  - Edge with waitrequest=0: go to WAIT_DATA; read drops the next cycle.
  - Edge with waitrequest=1: stay, counter+1.
  - readdatavalid in ISSUE is ignored.
- WAIT_DATA: flash_mem_read=0.
  - Edge with readdatavalid=1: capture the lane byte (lane0=[7:0], lane1=[15:8], lane2=[23:16], lane3=[31:24]) into recieved_data; timeout_flag=0; go to DONE.
  - Otherwise counter+1.
- Timeout: counter shared by ISSUE and WAIT_DATA.
  - On the edge where counter==TIMEOUT_CYCLES-1 and no completion condition holds: recieved_data=TIMEOUT_DATA, timeout_flag=1, read deasserted, go to DONE.
  - If valid and timeout coincide, valid wins.
- DONE: target_state_machine_finished=1 for exactly one cycle; unconditional return to IDLE.
  - start during DONE is ignored.
  - A start held high into IDLE is accepted on the next edge, so back-to-back requests are allowed.
- start during ISSUE/WAIT_DATA is ignored. The arbiter guarantees a single outstanding request; no queuing.
- Latency, zero-wait flash (start sampled at edge E0, waitrequest=0 at E1, valid at E2): finished high during cycle E2..E3. Minimum 3 cycles start-to-finish.
- Address wrap: none. arg bits above 24 are discarded; 25'h1FFFFFF reads word 23'h7FFFFF, lane 3.
- recieved_data and timeout_flag change only on a DONE entry or on reset.

Test Plan:
- Reset: assert rst mid-ISSUE with read=1 → read drops in the same cycle with no clock edge needed; recieved_data=00, finished=0, state IDLE after release.
- Zero-wait read: arg=32'h0000_0006, readdata=32'hA1B2C3D4, valid 1 cycle after accept → address=23'h1, recieved_data=8'hB2, finished pulse exactly 1 cycle, 3 cycles after start.
- Stall: waitrequest high 4 cycles, then valid 2 cycles later, lane 3 of 32'h5A000000 → read held 5 cycles with stable address; recieved_data=8'h5A; timeout_flag=0.
- Timeout: TIMEOUT_CYCLES=8, valid never asserted → finished after 8 cycles in ISSUE/WAIT_DATA; recieved_data=8'hFF, timeout_flag=1. Next good read clears the flag.
- Busy ignore and back-to-back: second start pulse during WAIT_DATA → no second read issued. Start held high through DONE → new ISSUE begins on the first IDLE edge with the new arguments latched.
- Spurious valid: readdatavalid pulsed in IDLE and in ISSUE → recieved_data unchanged, no finish pulse.
